// File: rtl/stim_fetch_if.sv
// Avalon-MM read-master bus between stim_fetch and the test-program SRAM.
interface stim_fetch_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
) ();
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_read;
  logic [DATA_WIDTH-1:0] mem_readdata;
  logic                  mem_waitrequest;

  modport master (
    output mem_address, mem_read,
    input  mem_readdata, mem_waitrequest
  );

  modport slave (
    input  mem_address, mem_read,
    output mem_readdata, mem_waitrequest
  );
endinterface

// File: rtl/stim_fetch.sv
// Test-program walker: reads 4-word records, feeds stimulus/check FIFOs and checker bitmask commands.
// Optional macro STIM_VEC_COUNT_EN adds a saturating vec_count output.
module stim_fetch #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned STF_WIDTH  = 24,
  parameter int unsigned RTF_WIDTH  = 24,
  parameter int unsigned ORV_WIDTH  = 8,
  parameter int unsigned CHF_WIDTH  = RTF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
  parameter int unsigned SCC_WIDTH  = 5,
  parameter int unsigned SCD_WIDTH  = 24
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] prog_base,
  input  logic [ADDR_WIDTH-1:0] res_base,
  output logic                  busy,
  output logic                  done,
  stim_fetch_if.master          mem,
  output logic [STF_WIDTH-1:0]  sfifo_data,
  output logic                  sfifo_wrreq,
  input  logic                  sfifo_wrfull,
  output logic [CHF_WIDTH-1:0]  cfifo_data,
  output logic                  cfifo_wrreq,
  input  logic                  cfifo_wrfull,
  output logic [SCC_WIDTH-1:0]  sc_cmd,
  output logic [SCD_WIDTH-1:0]  sc_data,
  output logic                  sc_switching,
  input  logic                  sc_ready
`ifdef STIM_VEC_COUNT_EN
  ,
  output logic [15:0]           vec_count
`endif
);

  localparam int unsigned IDX_WIDTH = 2;
  localparam logic [2:0] OP_VEC = 3'b001;
  localparam logic [2:0] OP_BM  = 3'b010;
  localparam logic [SCC_WIDTH-1:0] CMD_BITMASK = SCC_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_PUSH, S_WAIT_CHK, S_SEND_CMD, S_DONE
  } state_t;

  state_t                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0]            res_q, res_d;
  logic [IDX_WIDTH-1:0]             idx_q, idx_d;
  logic [3:0][DATA_WIDTH-1:0]       words_q, words_d;
  logic                             busy_q, busy_d;
  logic                             done_q, done_d;
  logic                             mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0]            mem_address_q, mem_address_d;
  logic [STF_WIDTH-1:0]             sfifo_data_q, sfifo_data_d;
  logic                             sfifo_wrreq_q, sfifo_wrreq_d;
  logic [CHF_WIDTH-1:0]             cfifo_data_q, cfifo_data_d;
  logic                             cfifo_wrreq_q, cfifo_wrreq_d;
  logic [SCC_WIDTH-1:0]             sc_cmd_q, sc_cmd_d;
  logic [SCD_WIDTH-1:0]             sc_data_q, sc_data_d;
  logic                             sc_switching_q, sc_switching_d;
`ifdef STIM_VEC_COUNT_EN
  logic [15:0]                      vec_count_q, vec_count_d;
`endif

  // Record fields decoded from the captured words
  logic [2:0]           op_rd;
  logic [2:0]           op_rec;
  logic [STF_WIDTH-1:0] field;
  logic [RTF_WIDTH-1:0] expected;
  logic [ORV_WIDTH-1:0] orv;
  logic                 unused_w0;

  assign op_rd     = mem.mem_readdata[DATA_WIDTH-1 -: 3];
  assign op_rec    = words_q[0][DATA_WIDTH-1 -: 3];
  assign field     = STF_WIDTH'({words_q[0][7:0], words_q[1]});
  assign expected  = RTF_WIDTH'({words_q[2], words_q[3][DATA_WIDTH-1:8]});
  assign orv       = ORV_WIDTH'(words_q[3][7:0]);
  assign unused_w0 = &{1'b0, words_q[0][DATA_WIDTH-4:8]};

  // Next-state and next-output logic; outputs are registered from the next state
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    res_d         = res_q;
    idx_d         = idx_q;
    words_d       = words_q;
    sfifo_data_d  = sfifo_data_q;
    cfifo_data_d  = cfifo_data_q;
    sfifo_wrreq_d = 1'b0;
    cfifo_wrreq_d = 1'b0;
`ifdef STIM_VEC_COUNT_EN
    vec_count_d   = vec_count_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d   = prog_base;
          res_d   = res_base;
          idx_d   = '0;
          state_d = S_FETCH;
`ifdef STIM_VEC_COUNT_EN
          vec_count_d = '0;
`endif
        end
      end
      S_FETCH: begin
        if (!mem.mem_waitrequest) begin
          words_d[idx_q] = mem.mem_readdata;
          ptr_d          = ptr_q + ADDR_WIDTH'(1);
          idx_d          = idx_q + IDX_WIDTH'(1);
          if (idx_q == '0 && op_rd != OP_VEC && op_rd != OP_BM) begin
            state_d = S_DONE;
          end else if (idx_q == IDX_WIDTH'(3)) begin
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        if (op_rec == OP_VEC)     state_d = S_PUSH;
        else if (op_rec == OP_BM) state_d = S_WAIT_CHK;
        else                      state_d = S_DONE;
      end
      S_PUSH: begin
        // Both FIFOs must have room so the pair is written atomically
        if (!sfifo_wrfull && !cfifo_wrfull) begin
          sfifo_wrreq_d = 1'b1;
          cfifo_wrreq_d = 1'b1;
          sfifo_data_d  = field;
          cfifo_data_d  = {expected, res_q, orv};
          res_d         = res_q + ADDR_WIDTH'(2);
          idx_d         = '0;
          state_d       = S_FETCH;
`ifdef STIM_VEC_COUNT_EN
          if (vec_count_q != 16'hFFFF) vec_count_d = vec_count_q + 16'd1;
`endif
        end
      end
      S_WAIT_CHK: begin
        if (sc_ready) state_d = S_SEND_CMD;
      end
      S_SEND_CMD: begin
        idx_d   = '0;
        state_d = S_FETCH;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d         = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d         = (state_d == S_DONE);
    mem_read_d     = (state_d == S_FETCH);
    mem_address_d  = ptr_d;
    sc_switching_d = (state_d == S_WAIT_CHK) || (state_d == S_SEND_CMD);
    sc_cmd_d       = (state_d == S_SEND_CMD) ? CMD_BITMASK : '0;
    sc_data_d      = (state_d == S_SEND_CMD) ? SCD_WIDTH'(field) : '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      ptr_q          <= '0;
      res_q          <= '0;
      idx_q          <= '0;
      words_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_read_q     <= 1'b0;
      mem_address_q  <= '0;
      sfifo_data_q   <= '0;
      sfifo_wrreq_q  <= 1'b0;
      cfifo_data_q   <= '0;
      cfifo_wrreq_q  <= 1'b0;
      sc_cmd_q       <= '0;
      sc_data_q      <= '0;
      sc_switching_q <= 1'b0;
`ifdef STIM_VEC_COUNT_EN
      vec_count_q    <= '0;
`endif
    end else begin
      state_q        <= state_d;
      ptr_q          <= ptr_d;
      res_q          <= res_d;
      idx_q          <= idx_d;
      words_q        <= words_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_read_q     <= mem_read_d;
      mem_address_q  <= mem_address_d;
      sfifo_data_q   <= sfifo_data_d;
      sfifo_wrreq_q  <= sfifo_wrreq_d;
      cfifo_data_q   <= cfifo_data_d;
      cfifo_wrreq_q  <= cfifo_wrreq_d;
      sc_cmd_q       <= sc_cmd_d;
      sc_data_q      <= sc_data_d;
      sc_switching_q <= sc_switching_d;
`ifdef STIM_VEC_COUNT_EN
      vec_count_q    <= vec_count_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign mem.mem_read    = mem_read_q;
  assign mem.mem_address = mem_address_q;
  assign sfifo_data      = sfifo_data_q;
  assign sfifo_wrreq     = sfifo_wrreq_q;
  assign cfifo_data      = cfifo_data_q;
  assign cfifo_wrreq     = cfifo_wrreq_q;
  assign sc_cmd          = sc_cmd_q;
  assign sc_data         = sc_data_q;
  assign sc_switching    = sc_switching_q;
`ifdef STIM_VEC_COUNT_EN
  assign vec_count       = vec_count_q;
`endif

endmodule

// File: doc/stim_fetch.md
Name: stim_fetch

Overview:
- Upstream neighbour of the result checker.
- Walks a test program stored in SRAM through an Avalon-MM read master (via mem_if).
- Splits each test vector into:
  - a stimulus word for the DUT driver FIFO (STIM_FIFO);
  - a check word for CHECK_FIFO: expected output, result address, OR value.
- Issues bitmask commands to the checker over the CHECK<=>STIM sideband, only when the checker is idle.

Parameters:
ADDR_WIDTH, 20, memory word address width
DATA_WIDTH, 16, memory data width
STF_WIDTH, 24, stimulus vector width
RTF_WIDTH, 24, expected-result vector width
ORV_WIDTH, 8, OR value width
CHF_WIDTH, RTF_WIDTH+ORV_WIDTH+ADDR_WIDTH, check FIFO word width
SCC_WIDTH, 5, sideband command width
SCD_WIDTH, 24, sideband data width

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin program at prog_base
prog_base  in  ADDR_WIDTH  program start word address
res_base  in  ADDR_WIDTH  first result write address
busy  out  1  high from accepted start until DONE
done  out  1  one-cycle pulse on END record
mem_address  out  ADDR_WIDTH  read address
mem_read  out  1  read request
mem_readdata  in  DATA_WIDTH  read data, valid when mem_read & ~mem_waitrequest
mem_waitrequest  in  1  stall
sfifo_data  out  STF_WIDTH  stimulus vector
sfifo_wrreq  out  1  stimulus write
sfifo_wrfull  in  1  stimulus FIFO full
cfifo_data  out  CHF_WIDTH  {expected, result address, OR value}, MSB first
cfifo_wrreq  out  1  check write
cfifo_wrfull  in  1  check FIFO full
sc_cmd  out  SCC_WIDTH  00000 idle, 00001 bitmask
sc_data  out  SCD_WIDTH  bitmask value
sc_switching  out  1  high while a command is pending or issued
sc_ready  in  1  checker idle with both of its FIFOs empty

Behaviour:
- Reset: state IDLE; every output 0, except mem_address = 0. Internal pointers 0.

Record format: 4 words, fixed stride.
- w0[15:13] opcode: 000 END, 001 VECTOR, 010 BITMASK; other codes are treated as END.
- w0[7:0] = field[23:16]; w1 = field[15:0].
- w2 = expected[23:8]; w3 = {expected[7:0], orv[7:0]}.

States: IDLE, FETCH, DECODE, PUSH, WAIT_CHK, SEND_CMD, DONE.
- IDLE:
  - on start, latch prog_base into the read pointer and res_base into the result pointer; set busy; go to FETCH, word index 0.
  - start is ignored in every other state.
- FETCH:
  - mem_read=1, mem_address = pointer.
  - Each cycle with ~mem_waitrequest: capture mem_readdata into word[idx], then pointer+1 and idx+1.
  - Address is held stable while mem_waitrequest is high.
  - After w0 is captured with an END opcode, go to DONE immediately; w1-w3 are not read.
  - After w3 is captured, go to DECODE.
- DECODE (1 cycle): VECTOR -> PUSH; BITMASK -> WAIT_CHK.
- PUSH:
  - Wait until ~sfifo_wrfull & ~cfifo_wrfull.
  - Then assert sfifo_wrreq and cfifo_wrreq together for exactly one cycle.
  - sfifo_data = field. cfifo_data = {expected, result pointer, orv}.
  - result pointer += 2 (the checker writes 2 words per result).
  - Next: FETCH, idx 0.
- WAIT_CHK: sc_switching=1; wait for sc_ready=1.
- SEND_CMD (1 cycle):
  - sc_cmd=00001, sc_data=field, sc_switching=1.
  - Next: FETCH.
  - sc_cmd returns to 00000 the following cycle.
- DONE: done=1 for one cycle, busy=0, go to IDLE.

Width rules and boundaries:
- Pointers wrap modulo 2^ADDR_WIDTH, with no error.
- The two FIFO writes are never split: one full FIFO stalls both.
- mem_read is never high outside FETCH.
- Async reset mid-record abandons the record; no FIFO write or sideband command is emitted afterwards.

Optional Feature:
Macro STIM_VEC_COUNT_EN.
- Defined: adds output vec_count [15:0].
  - Cleared on accepted start.
  - Incremented on each PUSH write.
  - Saturates at FFFF.
  - Holds its value after DONE.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Program at 0x00100: VECTOR field=0xABCDEF, expected=0x123456, orv=0x5A; then END. res_base=0x40000 -> one write each: sfifo_data=0xABCDEF, cfifo_data={0x123456,0x40000,0x5A}; done pulses 1 cycle after the read of 0x00104.
- Three VECTORs -> cfifo result addresses 0x40000, 0x40002, 0x40004; memory reads at 0x100-0x10B, then 0x10C.
- mem_waitrequest held high 3 cycles on w2 -> address stays 0x102 throughout; captured data correct; no extra reads.
- BITMASK 0x00FF00 with sc_ready=0 for 5 cycles -> sc_switching high, sc_cmd=0; one cycle after sc_ready rises, sc_cmd=00001, sc_data=0x00FF00 for exactly 1 cycle.
- cfifo_wrfull high 4 cycles during PUSH -> neither wrreq asserted; both pulse together once full drops.
- reset_n low during FETCH of the 2nd record -> all outputs 0 immediately; no FIFO write afterwards; new start restarts at prog_base.
